// File: rtl/uart_tx_path_if.sv
// Write-side bus of the UART transmit path: byte enqueue, FIFO flush and
// FIFO status flags seen by the producer.
interface uart_tx_path_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  fifo_reset;
    logic                  tx_empty;
    logic                  tx_full;
    logic [LEVEL_W-1:0]    tx_level;
    logic                  overflow_error;

    modport master (
        output wr_data, wr_en, fifo_reset,
        input  tx_empty, tx_full, tx_level, overflow_error
    );

    modport slave (
        input  wr_data, wr_en, fifo_reset,
        output tx_empty, tx_full, tx_level, overflow_error
    );
endinterface

// File: rtl/uart_tx_path.sv
// UART transmit path: TX FIFO feeding an 8N1-style serializer paced by an
// external oversample tick; the serial line comes straight from a flop.
module uart_tx_path #(
    parameter int FIFO_DEPTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int OVERSAMPLE_RATE = 16
) (
    input  logic          uart_clk,
    input  logic          rst_n,
    input  logic          sample_tick,
    uart_tx_path_if.slave wr_bus,
    output logic          tx_serial,
    output logic          tx_active,
    output logic          tx_done
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int TICK_W = (OVERSAMPLE_RATE > 1) ? $clog2(OVERSAMPLE_RATE) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [LVL_W-1:0]      level;
    logic                  overflow;
    logic [TICK_W-1:0]     tick_cnt, tick_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_nxt;
    logic [DATA_WIDTH-1:0] shift, shift_nxt;
    logic                  serial_nxt;
    logic                  full, empty, push, pop, bit_end;

    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    // Flush wins over a concurrent write; full is judged on pre-edge occupancy.
    assign push    = wr_bus.wr_en && !full && !wr_bus.fifo_reset;
    assign bit_end = sample_tick && (tick_cnt == TICK_W'(OVERSAMPLE_RATE - 1));

    assign wr_bus.tx_empty       = empty;
    assign wr_bus.tx_full        = full;
    assign wr_bus.tx_level       = level;
    assign wr_bus.overflow_error = overflow;
    assign tx_active             = (state != IDLE);

    always_ff @(posedge uart_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_bus.wr_data;
        end
    end

    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (wr_bus.fifo_reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (wr_bus.wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        tick_nxt   = tick_cnt;
        bit_nxt    = bit_cnt;
        shift_nxt  = shift;
        pop        = 1'b0;
        tx_done    = 1'b0;
        serial_nxt = 1'b1;

        if (state != IDLE && sample_tick) begin
            tick_nxt = bit_end ? '0 : tick_cnt + TICK_W'(1);
        end

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt   = bit_cnt + BIT_W'(1);
                        shift_nxt = shift >> 1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Line level is derived from the state being entered so the flop
        // presents it in the first cycle of that state.
        case (state_nxt)
            START:   serial_nxt = 1'b0;
            DATA:    serial_nxt = shift_nxt[0];
            default: serial_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            tx_serial <= 1'b1;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_nxt;
            bit_cnt   <= bit_nxt;
            tx_serial <= serial_nxt;
        end
    end

    always_ff @(posedge uart_clk) begin
        shift <= shift_nxt;
    end
endmodule

// File: tb/tb_uart_tx_path.sv
// Bench for uart_tx_path: queue-based frame model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_uart_tx_path;
    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int OS    = 16;

    logic uart_clk = 1'b0;
    logic rst_n    = 1'b0;
    logic sample_tick = 1'b0;
    logic tx_serial, tx_active, tx_done;

    uart_tx_path_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) wr_bus ();

    uart_tx_path #(
        .FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .OVERSAMPLE_RATE(OS)
    ) dut (
        .uart_clk    (uart_clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .wr_bus      (wr_bus),
        .tx_serial   (tx_serial),
        .tx_active   (tx_active),
        .tx_done     (tx_done)
    );

    always #5 uart_clk = ~uart_clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;
    int done_cnt = 0;
    int tick_div = 1;
    int tick_ph  = 0;

    // Frame model: a byte queue, and the in-flight frame as a list of ten line levels.
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    bit         m_ovf  = 0;
    bit         m_busy = 0;
    bit         m_bits[10];
    int         m_idx   = 0;
    int         m_ticks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge uart_clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] d);
        wr_bus.wr_data = d;
        wr_bus.wr_en   = 1'b1;
        step(1);
        wr_bus.wr_en   = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge uart_clk);
            #1;
            if (tick_div <= 0) begin
                sample_tick = 1'b0;
            end else begin
                sample_tick = (tick_ph == 0);
                tick_ph     = (tick_ph + 1) % tick_div;
            end
        end
    end

    initial begin
        forever begin
            @(posedge uart_clk);
            if (!rst_n) begin
                m_q.delete();
                m_ovf = 0; m_busy = 0; m_idx = 0; m_ticks = 0;
            end else begin
                automatic int  pre_size = m_q.size();
                automatic bit  do_pop   = !m_busy && (pre_size > 0);
                if (m_busy && sample_tick) begin
                    m_ticks++;
                    if (m_ticks == OS) begin
                        m_ticks = 0;
                        m_idx++;
                        if (m_idx == 10) begin
                            m_busy = 0;
                            m_idx  = 0;
                        end
                    end
                end
                if (do_pop) begin
                    automatic logic [7:0] b = m_q.pop_front();
                    m_sent.push_back(b);
                    m_bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) m_bits[i+1] = b[i];
                    m_bits[9] = 1'b1;
                    m_busy = 1; m_idx = 0; m_ticks = 0;
                end
                if (wr_bus.fifo_reset) begin
                    m_q.delete();
                    m_ovf = 0;
                end else if (wr_bus.wr_en) begin
                    if (pre_size == DEPTH) m_ovf = 1;
                    else m_q.push_back(wr_bus.wr_data);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge uart_clk);
            if (tx_done === 1'b1) done_cnt++;
            if (chk_en) begin
                chk("cyc_serial", tx_serial, m_busy ? m_bits[m_idx] : 1'b1);
                chk("cyc_active", tx_active, m_busy);
                chk("cyc_done", tx_done,
                    m_busy && m_idx == 9 && sample_tick && m_ticks == OS - 1);
                chk("cyc_level", wr_bus.tx_level, m_q.size());
                chk("cyc_empty", wr_bus.tx_empty, m_q.size() == 0);
                chk("cyc_full", wr_bus.tx_full, m_q.size() == DEPTH);
                chk("cyc_ovf", wr_bus.overflow_error, m_ovf);
            end
        end
    end

    initial begin
        automatic int a5_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        automatic logic [7:0] ovf_order[9] = '{8'h5A, 8'h00, 8'h01, 8'h02, 8'h03,
                                                8'h04, 8'h05, 8'h06, 8'h07};
        int cur, base, highs, w, zeros;
        wr_bus.wr_data    = '0;
        wr_bus.wr_en      = 1'b0;
        wr_bus.fifo_reset = 1'b0;
        rst_n = 1'b0;
        step(3);
        chk_en = 1;
        @(negedge uart_clk);
        chk("rst_serial", tx_serial, 1);
        chk("rst_empty", wr_bus.tx_empty, 1);
        chk("rst_full", wr_bus.tx_full, 0);
        chk("rst_level", wr_bus.tx_level, 0);
        chk("rst_active", tx_active, 0);
        chk("rst_ovf", wr_bus.overflow_error, 0);
        rst_n = 1'b1;
        step(2);

        // 0xA5, tick every cycle
        tick_div = 1;
        base = done_cnt;
        wr(8'hA5);
        @(negedge uart_clk);
        chk("a5_idle_before_start", tx_serial, 1);
        step(1);
        cur = 0;
        for (int k = 0; k < 10; k++) begin
            step(16 * k + 8 - cur);
            cur = 16 * k + 8;
            @(negedge uart_clk);
            chk("a5_bit", tx_serial, a5_seq[k]);
        end
        step(165 - cur);
        @(negedge uart_clk);
        chk("a5_active_after", tx_active, 0);
        chk("a5_done_pulses", done_cnt - base, 1);
        step(1);

        // 0x01 then 0xFF back to back
        base = done_cnt;
        wr(8'h01);
        wr(8'hFF);
        step(143);
        @(negedge uart_clk);
        chk("b2b_last_data_bit", tx_serial, 0);
        step(1);
        highs = 0;
        while (highs < 40) begin
            @(negedge uart_clk);
            if (tx_serial !== 1'b1) break;
            highs++;
            step(1);
        end
        chk("b2b_gap_high_cycles", highs, 17);
        step(180);
        chk("b2b_done_pulses", done_cnt - base, 2);

        // overflow with FSM stalled in START
        tick_div = 0;
        step(1);
        m_sent.delete();
        wr(8'h5A);
        step(2);
        for (int i = 0; i < 9; i++) wr(8'(i));
        @(negedge uart_clk);
        chk("ovf_full", wr_bus.tx_full, 1);
        chk("ovf_level", wr_bus.tx_level, 8);
        chk("ovf_flag", wr_bus.overflow_error, 1);
        tick_div = 1;
        step(9 * 161 + 20);
        @(negedge uart_clk);
        chk("ovf_drained_level", wr_bus.tx_level, 0);
        chk("ovf_sticky", wr_bus.overflow_error, 1);
        chk("ovf_sent_count", m_sent.size(), 9);
        for (int i = 0; i < 9 && i < m_sent.size(); i++) chk("ovf_sent_order", m_sent[i], ovf_order[i]);

        // 0x3C, tick every 4th cycle
        tick_div = 4;
        step(1);
        wr(8'h3C);
        step(1);
        @(negedge uart_clk);
        chk("slow_start_bit", tx_serial, 0);
        w = 0;
        while (w < 400) begin
            @(negedge uart_clk);
            if (tx_serial === 1'b1) break;
            w++;
            step(1);
        end
        chk("slow_found_high", w < 400, 1);
        highs = 1;
        step(1);
        while (highs < 400) begin
            @(negedge uart_clk);
            if (tx_serial !== 1'b1) break;
            highs++;
            step(1);
        end
        chk("slow_four_ones_cycles", highs, 256);
        step(300);
        @(negedge uart_clk);
        chk("slow_active_after", tx_active, 0);

        // reset mid-frame
        tick_div = 1;
        step(2);
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        step(70);
        @(negedge uart_clk);
        chk("rmid_level_before", wr_bus.tx_level, 3);
        chk("rmid_active_before", tx_active, 1);
        base = done_cnt;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        @(negedge uart_clk);
        chk("rmid_serial", tx_serial, 1);
        chk("rmid_level", wr_bus.tx_level, 0);
        chk("rmid_active", tx_active, 0);
        zeros = 0;
        repeat (200) begin
            @(negedge uart_clk);
            if (tx_serial !== 1'b1) zeros++;
            step(1);
        end
        chk("rmid_nothing_sent", zeros, 0);
        chk("rmid_no_done", done_cnt - base, 0);

        // fifo_reset mid-frame with 5 queued and overflow set
        wr(8'h80);
        wr(8'h81);
        @(negedge uart_clk);
        chk("simul_push_pop_level", wr_bus.tx_level, 1);
        for (int i = 2; i < 10; i++) wr(8'h80 + 8'(i));
        w = 0;
        while (w < 1000) begin
            @(negedge uart_clk);
            if (wr_bus.tx_level == 5) break;
            w++;
            step(1);
        end
        chk("frst_wait_level5", w < 1000, 1);
        chk("frst_ovf_before", wr_bus.overflow_error, 1);
        step(40);
        wr_bus.fifo_reset = 1'b1;
        wr_bus.wr_en      = 1'b1;
        wr_bus.wr_data    = 8'hEE;
        step(1);
        wr_bus.fifo_reset = 1'b0;
        wr_bus.wr_en      = 1'b0;
        @(negedge uart_clk);
        chk("frst_level", wr_bus.tx_level, 0);
        chk("frst_ovf", wr_bus.overflow_error, 0);
        chk("frst_frame_continues", tx_active, 1);
        base = done_cnt;
        step(200);
        @(negedge uart_clk);
        chk("frst_active_after", tx_active, 0);
        chk("frst_done_one", done_cnt - base, 1);
        chk("frst_empty_after", wr_bus.tx_empty, 1);
        step(2);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_path.md
UART_TX_PATH -- requirements
Module: uart_tx_path

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, TX FIFO depth in entries (power of two, >=2).
REQ-002 Parameter DATA_WIDTH, default 8, data bits per frame.
REQ-003 Parameter OVERSAMPLE_RATE, default 16, sample_tick pulses per serial bit.
REQ-004 uart_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 sample_tick  input  1  single-cycle oversample enable from the baud generator.
REQ-007 wr_data  input  DATA_WIDTH  byte to enqueue.
REQ-008 wr_en  input  1  enqueue request, sampled each cycle.
REQ-009 fifo_reset  input  1  synchronous flush of the FIFO and the error flag.
REQ-010 tx_serial  output  1  serial line, idle high.
REQ-011 tx_empty  output  1  FIFO holds zero entries.
REQ-012 tx_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-013 tx_level  output  $clog2(FIFO_DEPTH)+1 (4 at default)  FIFO occupancy.
REQ-014 tx_active  output  1  frame in progress.
REQ-015 tx_done  output  1  one-cycle pulse at the end of each stop bit.
REQ-016 overflow_error  output  1  sticky: a write was attempted while full.

Function
REQ-017 FIFO SHALL accept wr_data when wr_en=1 and tx_full=0; when tx_full=1 the write SHALL be dropped and overflow_error SHALL set on the next edge.
REQ-018 Full/empty decisions SHALL use the pre-edge occupancy; a write and a pop in the same cycle while full SHALL drop the write, and while non-full SHALL both take effect with tx_level unchanged.
REQ-019 Read and write pointers SHALL wrap modulo FIFO_DEPTH; tx_level SHALL never exceed FIFO_DEPTH or go below 0.
REQ-020 tx_level SHALL count FIFO entries only, excluding the byte in the shift register.
REQ-021 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-022 IDLE with tx_empty=0: pop head into the shift register, clear tick and bit counters, go to START on the next edge; no pop in any other state.
REQ-023 Tick counter SHALL increment only on sample_tick; a bit period ends on the sample_tick where the counter equals OVERSAMPLE_RATE-1, and the counter then wraps to 0.
REQ-024 START drives tx_serial=0 for one bit period, then goes to DATA.
REQ-025 DATA drives DATA_WIDTH bits LSB first, one bit period each, then goes to STOP.
REQ-026 STOP drives tx_serial=1 for one bit period, asserts tx_done for the cycle of its final tick, then goes to IDLE.
REQ-027 IDLE drives tx_serial=1; a non-empty FIFO SHALL start the next frame one cycle after STOP ends (back-to-back, one stop bit).
REQ-028 tx_active SHALL be 1 exactly in START, DATA and STOP.
REQ-029 Latency: wr_en at cycle N into an empty FIFO with FSM in IDLE -> pop at N+1 -> tx_serial=0 from N+2.
REQ-030 tx_serial SHALL be driven from a register (glitch-free).
REQ-031 fifo_reset SHALL empty the FIFO and clear overflow_error on the next edge without aborting the frame in progress; a concurrent wr_en SHALL be ignored.
REQ-032 overflow_error SHALL stay set until rst_n=0 or fifo_reset=1.

Reset
REQ-033 While rst_n=0 on an edge: FSM=IDLE, counters=0, FIFO empty, tx_serial=1, tx_empty=1, tx_full=0, tx_level=0, tx_active=0, tx_done=0, overflow_error=0.
REQ-034 Reset mid-frame SHALL abort the frame; tx_serial=1 from the edge after reset is sampled; the aborted byte and FIFO contents are discarded.

Verification
REQ-035 sample_tick=1 every cycle, write 0xA5 -> tx_serial = 0,1,0,1,0,0,1,0,1,1 for 16 cycles each (160 cycles), tx_done one pulse, tx_active=0 afterwards.
REQ-036 Write 0x01 then 0xFF in consecutive cycles -> two frames with exactly 16 cycles of stop-level high between the last data bit of frame 1 and the start bit of frame 2, plus one IDLE cycle.
REQ-037 FSM held busy, write 9 bytes (0x00..0x08) -> first 8 accepted, tx_full=1, tx_level=8, 9th dropped, overflow_error=1 sticky; transmitted order 0x00..0x07.
REQ-038 sample_tick every 4th cycle, write 0x3C -> each bit lasts 64 cycles and frame content is unchanged.
REQ-039 Assert rst_n=0 during bit 3 of a frame with 3 bytes queued -> tx_serial=1, tx_level=0, tx_active=0, nothing further transmitted.
REQ-040 fifo_reset=1 mid-frame with 5 bytes queued and overflow_error=1 -> current frame completes, tx_level=0, overflow_error=0, FSM returns to IDLE.
